// File: rtl/pipeline_stage_ctrl.sv
// Pipeline latch sequencer: turns hazard-unit flush/freeze requests, cache hits and halt
// into per-latch enable/clear strobes, PC enable, per-latch valid bits and a stall counter.
//
// mode    | meaning
// run     | halted=0: strobes follow mem_stall / flush / freeze / fetch priority
// halted  | halted=1: all strobes low, all state frozen until RST
module pipeline_stage_ctrl #(
    parameter int NLATCH = 4,
    parameter int CNTW   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NLATCH-1:0] flush,
    input  logic [NLATCH-1:0] freeze,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              dmem_req_m,
    input  logic              halt_wb,
    output logic [NLATCH-1:0] latch_en,
    output logic [NLATCH-1:0] latch_clr,
    output logic [NLATCH-1:0] valid,
    output logic              pc_en,
    output logic              halted,
    output logic [CNTW-1:0]   stall_count
);

    localparam int EXMEM = NLATCH - 2;
    localparam int MEMWB = NLATCH - 1;

    logic [NLATCH-1:0] pend_flush;
    logic [NLATCH-1:0] fl_eff;
    logic [NLATCH-1:0] frz_eff;
    logic [NLATCH-1:0] bubble;
    logic [NLATCH-1:0] valid_src;
    logic [NLATCH-1:0] valid_nxt;
    logic              mem_stall;

    assign mem_stall = dmem_req_m & valid[EXMEM] & ~dhit;
    assign fl_eff    = flush | pend_flush;

    // A freeze on latch j also holds every latch upstream of it.
    always_comb begin
        frz_eff = '0;
        for (int i = 0; i < NLATCH; i++) begin
            frz_eff[i] = |(freeze >> i);
        end
    end

    // Bubble source: a frozen neighbour upstream, or a fetch miss for IF/ID.
    assign bubble    = {frz_eff[NLATCH-2:0], ~ihit};
    assign valid_src = {valid[NLATCH-2:0], 1'b1};

    always_comb begin
        latch_en  = '0;
        latch_clr = '0;
        valid_nxt = valid;
        pc_en     = 1'b0;
        if (RST) begin
            latch_clr = '1;
        end else if (!halted && !mem_stall) begin
            for (int i = 0; i < NLATCH; i++) begin
                if (fl_eff[i]) begin
                    latch_clr[i] = 1'b1;
                    valid_nxt[i] = 1'b0;
                end else if (frz_eff[i]) begin
                    valid_nxt[i] = valid[i];
                end else if (bubble[i]) begin
                    latch_clr[i] = 1'b1;
                    valid_nxt[i] = 1'b0;
                end else begin
                    latch_en[i]  = 1'b1;
                    valid_nxt[i] = valid_src[i];
                end
            end
            // A flushed IF/ID means the branch path redirects the PC instead.
            pc_en = ihit & ~frz_eff[0] & ~fl_eff[0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid       <= '0;
            pend_flush  <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else if (!halted) begin
            if (mem_stall) begin
                pend_flush <= pend_flush | flush;
            end else begin
                pend_flush <= '0;
                valid      <= valid_nxt;
                if (valid[MEMWB] && halt_wb) begin
                    halted <= 1'b1;
                end
            end
            if (!pc_en && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Bench for pipeline_stage_ctrl: directed vector table, hand sequences, randomized
// traffic against a per-latch rule model, and the stall counter saturation run.
module tb_pipeline_stage_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  flush, freeze;
    logic        ihit, dhit, dmem_req_m, halt_wb;
    logic [3:0]  latch_en, latch_clr, valid;
    logic        pc_en, halted;
    logic [15:0] stall_count;

    always #5 CLK = ~CLK;

    pipeline_stage_ctrl #(.NLATCH(4), .CNTW(16)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze),
        .ihit(ihit), .dhit(dhit), .dmem_req_m(dmem_req_m), .halt_wb(halt_wb),
        .latch_en(latch_en), .latch_clr(latch_clr), .valid(valid),
        .pc_en(pc_en), .halted(halted), .stall_count(stall_count)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  flush, freeze;
        logic        ihit, dhit, dmem, halt;
        logic [3:0]  en, clr;
        logic        pc;
        logic [3:0]  vld;
        logic        hlt;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[25];
    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: valid bits, deferred flushes, halt flag, stall count.
    bit [3:0] mv, mp, nv, np;
    bit       mh, nh;
    int       mc, nc;
    logic [3:0] e_en, e_clr;
    logic       e_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] fl, input logic [3:0] fz,
                                input logic ih, input logic dh, input logic dm, input logic hw,
                                input logic [3:0] en, input logic [3:0] clr, input logic pc,
                                input logic [3:0] vld, input logic hlt, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.flush = fl; v.freeze = fz; v.ihit = ih; v.dhit = dh;
        v.dmem = dm; v.halt = hw; v.en = en; v.clr = clr; v.pc = pc;
        v.vld = vld; v.hlt = hlt; v.cnt = cnt;
        return v;
    endfunction

    task automatic model_eval();
        bit stall, kill, held, up_held;
        e_en = '0; e_clr = '0; e_pc = 1'b0;
        nv = mv; np = mp; nh = mh; nc = mc;
        if (RST) begin
            e_clr = 4'hF;
            nv = '0; np = '0; nh = 1'b0; nc = 0;
            return;
        end
        if (mh) return;
        stall = dmem_req_m && mv[2] && !dhit;
        if (stall) begin
            np = mp | flush;
        end else begin
            np = '0;
            for (int i = 0; i < 4; i++) begin
                kill = flush[i] || mp[i];
                held = 1'b0;
                for (int j = i; j < 4; j++) if (freeze[j]) held = 1'b1;
                up_held = 1'b0;
                if (i > 0) begin
                    for (int j = i - 1; j < 4; j++) if (freeze[j]) up_held = 1'b1;
                end else begin
                    up_held = !ihit;
                end
                if (kill) begin
                    e_clr[i] = 1'b1; nv[i] = 1'b0;
                end else if (held) begin
                    nv[i] = mv[i];
                end else if (up_held) begin
                    e_clr[i] = 1'b1; nv[i] = 1'b0;
                end else begin
                    e_en[i] = 1'b1;
                    if (i == 0) nv[0] = 1'b1;
                    else nv[i] = mv[i-1];
                end
            end
            e_pc = ihit && (freeze == 4'b0) && !(flush[0] || mp[0]);
            if (mv[3] && halt_wb) nh = 1'b1;
        end
        if (!e_pc && nc < 65535) nc = nc + 1;
    endtask

    task automatic commit();
        mv = nv; mp = np; mh = nh; mc = nc;
    endtask

    task automatic chk_comb_model();
        chk("model_latch_en", latch_en, e_en);
        chk("model_latch_clr", latch_clr, e_clr);
        chk("model_pc_en", pc_en, e_pc);
    endtask

    task automatic chk_reg_model();
        chk("model_valid", valid, mv);
        chk("model_halted", halted, mh);
        chk("model_stall_count", stall_count, mc);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic run_cycle();
        #4;
        model_eval();
        chk_comb_model();
        @(posedge CLK);
        #1;
        commit();
        chk_reg_model();
    endtask

    task automatic drive(input logic r, input logic [3:0] fl, input logic [3:0] fz,
                         input logic ih, input logic dh, input logic dm, input logic hw);
        RST = r; flush = fl; freeze = fz; ihit = ih; dhit = dh; dmem_req_m = dm; halt_wb = hw;
    endtask

    initial begin
        mv = '0; mp = '0; mh = 1'b0; mc = 0;
        drive(1, 0, 0, 0, 0, 0, 0);

        tbl[0]  = mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 4'h0, 0, 0);
        tbl[1]  = mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 4'h0, 0, 0);
        tbl[2]  = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h1, 0, 0);
        tbl[3]  = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h3, 0, 0);
        tbl[4]  = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h7, 0, 0);
        tbl[5]  = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'hF, 0, 0);
        tbl[6]  = mk(0, 4'h0, 4'h1, 1, 0, 0, 0, 4'hC, 4'h2, 0, 4'hD, 0, 1);
        tbl[7]  = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'hB, 0, 1);
        tbl[8]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'hE, 4'h1, 0, 4'h6, 0, 2);
        tbl[9]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'hE, 4'h1, 0, 4'hC, 0, 3);
        tbl[10] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h9, 0, 3);
        tbl[11] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h3, 0, 3);
        tbl[12] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h7, 0, 3);
        tbl[13] = mk(0, 4'h3, 4'h0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 4'h7, 0, 4);
        tbl[14] = mk(0, 4'h0, 4'h0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 4'h7, 0, 5);
        tbl[15] = mk(0, 4'h0, 4'h0, 1, 0, 1, 0, 4'h0, 4'h0, 0, 4'h7, 0, 6);
        tbl[16] = mk(0, 4'h0, 4'h0, 1, 1, 1, 0, 4'hC, 4'h3, 0, 4'hC, 0, 7);
        tbl[17] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h9, 0, 7);
        tbl[18] = mk(0, 4'h2, 4'h2, 1, 0, 0, 0, 4'h8, 4'h6, 0, 4'h1, 0, 8);
        tbl[19] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h3, 0, 8);
        tbl[20] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'h7, 0, 8);
        tbl[21] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'hF, 4'h0, 1, 4'hF, 0, 8);
        tbl[22] = mk(0, 4'h0, 4'h0, 1, 0, 0, 1, 4'hF, 4'h0, 1, 4'hF, 1, 8);
        tbl[23] = mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 4'h0, 4'h0, 0, 4'hF, 1, 8);
        tbl[24] = mk(1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 4'h0, 0, 0);

        @(posedge CLK);
        #1;

        for (int k = 0; k < 25; k++) begin
            drive(tbl[k].rst, tbl[k].flush, tbl[k].freeze, tbl[k].ihit,
                  tbl[k].dhit, tbl[k].dmem, tbl[k].halt);
            #4;
            model_eval();
            chk($sformatf("vec%0d_latch_en", k), latch_en, tbl[k].en);
            chk($sformatf("vec%0d_latch_clr", k), latch_clr, tbl[k].clr);
            chk($sformatf("vec%0d_pc_en", k), pc_en, tbl[k].pc);
            chk_comb_model();
            @(posedge CLK);
            #1;
            commit();
            chk($sformatf("vec%0d_valid", k), valid, tbl[k].vld);
            chk($sformatf("vec%0d_halted", k), halted, tbl[k].hlt);
            chk($sformatf("vec%0d_stall_count", k), stall_count, tbl[k].cnt);
            chk_reg_model();
        end

        // Reset in the middle of a memory stall must discard the deferred flush.
        drive(0, 4'h0, 4'h0, 1, 0, 0, 0);
        repeat (3) run_cycle();
        drive(0, 4'h1, 4'h0, 1, 0, 1, 0);
        run_cycle();
        drive(1, 4'h0, 4'h0, 1, 0, 1, 0);
        run_cycle();
        drive(0, 4'h0, 4'h0, 1, 1, 0, 0);
        run_cycle();
        chk("rst_drops_pend_flush", valid, 4'h1);

        // Flush arriving in the release cycle merges with the deferred one.
        drive(0, 4'h0, 4'h0, 1, 0, 0, 0);
        repeat (2) run_cycle();
        drive(0, 4'h1, 4'h0, 1, 0, 1, 0);
        run_cycle();
        drive(0, 4'h4, 4'h0, 1, 1, 1, 0);
        #4;
        chk("release_merge_clr", latch_clr, 4'h5);
        model_eval();
        chk_comb_model();
        @(posedge CLK);
        #1;
        commit();
        chk_reg_model();

        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 39) == 0,
                  {$urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0},
                  {$urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
                   $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0},
                  $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 60,
                  $urandom_range(0, 99) < 40, $urandom_range(0, 24) == 0);
            run_cycle();
        end

        drive(1, 4'h0, 4'h0, 0, 0, 0, 0);
        run_cycle();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 0);
        repeat (65540) @(posedge CLK);
        #1;
        chk("stall_count_saturates", stall_count, 16'hFFFF);
        drive(1, 4'h0, 4'h0, 0, 0, 0, 0);
        run_cycle();
        chk("stall_count_rst_after_sat", stall_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_ctrl.md
Name: pipeline_stage_ctrl

Overview:
- Consumer end of the hazard-unit flush/freeze bus.
- Turns per-latch flush/freeze requests, cache hit handshakes and the halt signal into latch enable/clear strobes for the four pipeline registers, plus the PC enable.
- Tracks a valid bit per latch, holds flushes that arrive during a memory stall, latches halt, and counts stall cycles.
- Sits between hazard_unit, the caches and the four pipeline latches in the datapath.

Parameters:
NLATCH, 4, number of pipeline latches (bit 0 IF/ID, 1 ID/EX, 2 EX/MEM, 3 MEM/WB)
CNTW, 16, stall counter width

Ports:
CLK  input  1  clock
RST  input  1  synchronous reset, active-high
flush  input  NLATCH  per-latch squash request from hazard unit
freeze  input  NLATCH  per-latch hold request from hazard unit
ihit  input  1  instruction cache hit (fetch word valid this cycle)
dhit  input  1  data cache hit
dmem_req_m  input  1  MEM-stage instruction is a load/store
halt_wb  input  1  MEM/WB latch holds a halt instruction
latch_en  output  NLATCH  latch i loads its input at next edge
latch_clr  output  NLATCH  latch i loads a bubble at next edge
valid  output  NLATCH  registered valid bit per latch
pc_en  output  1  PC may advance
halted  output  1  sticky halt flag
stall_count  output  CNTW  saturating count of cycles with pc_en low

Behaviour:
- Clocking and reset:
  - Single clock CLK, all state on its rising edge.
  - RST is synchronous and active-high.
  - Reset sets valid=0, halted=0, stall_count=0 and pend_flush=0.
  - While RST=1 the combinational outputs are latch_en=0, latch_clr=all ones, pc_en=0.
- Internal state: valid[3:0], pend_flush[3:0], halted, stall_count.
- Derived terms:
  - mem_stall = dmem_req_m & valid[2] & ~dhit.
  - frz_eff[i] = OR of freeze[j] for j>=i; a freeze propagates upstream.
  - fl_eff = flush | pend_flush.
- Priority per cycle, highest first:
  1. halted=1: latch_en=0, latch_clr=0, pc_en=0. All state holds except stall_count, which also holds. Only RST exits this state.
  2. mem_stall:
     - latch_en=0, latch_clr=0, pc_en=0.
     - pend_flush <= pend_flush | flush, so no flush is lost.
     - Valid bits hold.
  3. Otherwise, evaluated per latch i:
     - If fl_eff[i]: latch_clr[i]=1, latch_en[i]=0, valid[i] <= 0. Flush beats freeze on the same latch.
     - Else if frz_eff[i]: latch_en[i]=0, latch_clr[i]=0, valid holds.
     - Else if i>0 and frz_eff[i-1]: latch_clr[i]=1 and valid[i] <= 0. This inserts a bubble below the frozen latch.
     - Else if i=0 and ~ihit: latch_clr[0]=1 and valid[0] <= 0, giving a fetch bubble.
     - Else: latch_en[i]=1, valid[i] <= (i=0 ? 1 : valid[i-1]).
     - pc_en = ihit & ~frz_eff[0] & ~fl_eff[0]. Flushing IF/ID means the PC is redirected by the branch path, not incremented by this block.
     - pend_flush <= 0.
- latch_en and latch_clr are never both 1 for the same bit.
- Halt: if valid[3] & halt_wb & ~mem_stall, then halted <= 1 at the next edge. From that edge onward, rule 1 applies.
- stall_count: increments when pc_en=0 & ~halted & ~RST. It saturates at all ones and never wraps.
- Latency:
  - Flush takes effect on the valid bit one cycle after assertion.
  - A flush deferred by mem_stall takes effect on the first edge after dhit.
- Simultaneous flush and mem_stall: the flush is recorded in pend_flush; a new flush in the release cycle is ORed into it.
- RST asserted mid-stall or mid-halt clears everything at that edge, including pend_flush.

Test Plan:
- Reset/steady flow: RST=1 for 2 cycles, then ihit=1, all other inputs 0 for 4 cycles -> valid goes 0001, 0011, 0111, 1111; latch_en=1111 from the first post-reset cycle; pc_en=1; stall_count=0.
- Load-use freeze: steady pipe, freeze=0001 for 1 cycle -> latch_en=1100, latch_clr=0010, pc_en=0; valid[1]=0 next cycle; stall_count=1.
- Flush during memory stall: dmem_req_m=1, dhit=0 for 3 cycles, with flush=0011 pulsed in cycle 1 -> no strobes during the stall, pend_flush=0011. On the dhit cycle, latch_clr=0011; valid[1:0]=00 next cycle; stall_count=3.
- Flush vs. freeze on the same latch: flush=0010 and freeze=0010 together -> latch_clr[1]=1, latch_en[1]=0, latch_en[0]=0, pc_en=0.
- Fetch miss: ihit=0 for 2 cycles in steady flow -> latch_clr=0001, pc_en=0, downstream latches advance, stall_count=2.
- Halt and saturation: valid[3]=1 with halt_wb=1 -> halted=1 next edge and outputs frozen; stall_count holds. A separate run forcing a 65540-cycle ihit=0 stall must read 0xFFFF; RST then returns it to 0.
